// File: rtl/stopwatch_bcd_if.sv
// Control inputs and BCD display outputs of the stopwatch.
// The slave modport is the stopwatch side; the master modport is the driver/observer side.
interface stopwatch_bcd_if;
    logic       i_tick;
    logic       i_start_stop;
    logic       i_clear;
    logic [3:0] o_sec_ones;
    logic [3:0] o_sec_tens;
    logic [3:0] o_min_ones;
    logic [3:0] o_min_tens;
    logic       o_running;
    logic       o_wrap;

    modport slave (
        input  i_tick, i_start_stop, i_clear,
        output o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_running, o_wrap
    );

    modport master (
        output i_tick, i_start_stop, i_clear,
        input  o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_running, o_wrap
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// BCD MM:SS stopwatch with IDLE/RUN/PAUSE control, driven by a one-pulse-per-second tick.
// The minutes modulus is set by MINUTE_MOD (10..60 in steps of 10).
module stopwatch_bcd #(
    parameter int unsigned MINUTE_MOD = 60
) (
    input  logic            i_clk,
    input  logic            i_reset,
    stopwatch_bcd_if.slave  sw
);
    localparam logic [3:0] MIN_TENS_MAX = 4'(MINUTE_MOD / 10 - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t     state_q, state_d;
    logic       prev_q;
    logic       start_edge;
    logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
    logic       running_q, wrap_q;
    logic       c_sec_ones, c_sec_tens, c_min_ones, c_min_tens, c_full;

    assign start_edge = sw.i_start_stop & ~prev_q;

    // Each carry enables the next digit; the tick counted is the one seen in RUN,
    // even if a start edge moves the state to PAUSE on the same edge.
    assign c_sec_ones = (state_q == RUN) & sw.i_tick;
    assign c_sec_tens = c_sec_ones & (sec_ones_q == 4'd9);
    assign c_min_ones = c_sec_tens & (sec_tens_q == 4'd5);
    assign c_min_tens = c_min_ones & (min_ones_q == 4'd9);
    assign c_full     = c_min_tens & (min_tens_q == MIN_TENS_MAX);

    always_comb begin
        state_d = state_q;
        if (sw.i_clear) begin
            state_d = IDLE;
        end else if (start_edge) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            prev_q     <= 1'b0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
            sec_ones_q <= '0;
            sec_tens_q <= '0;
            min_ones_q <= '0;
            min_tens_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= sw.i_start_stop;
            // Decoding the next state keeps o_running aligned with state_q while staying registered.
            running_q <= (state_d == RUN);
            if (sw.i_clear) begin
                wrap_q     <= 1'b0;
                sec_ones_q <= '0;
                sec_tens_q <= '0;
                min_ones_q <= '0;
                min_tens_q <= '0;
            end else begin
                wrap_q <= c_full;
                if (c_sec_ones) sec_ones_q <= (sec_ones_q == 4'd9) ? 4'd0 : sec_ones_q + 4'd1;
                if (c_sec_tens) sec_tens_q <= (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
                if (c_min_ones) min_ones_q <= (min_ones_q == 4'd9) ? 4'd0 : min_ones_q + 4'd1;
                if (c_min_tens) min_tens_q <= (min_tens_q == MIN_TENS_MAX) ? 4'd0 : min_tens_q + 4'd1;
            end
        end
    end

    assign sw.o_sec_ones = sec_ones_q;
    assign sw.o_sec_tens = sec_tens_q;
    assign sw.o_min_ones = min_ones_q;
    assign sw.o_min_tens = min_tens_q;
    assign sw.o_running  = running_q;
    assign sw.o_wrap     = wrap_q;
endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 The block SHALL have parameter MINUTE_MOD, default 60, which is the minutes modulus; legal values are 10, 20, 30, 40, 50 and 60.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_tick, input, 1 bit: one-cycle count enable, driven by the upstream mod-k counter's rollover output (one pulse per second).
REQ-005 The block SHALL have port i_start_stop, input, 1 bit: debounced level; each 0->1 edge toggles run/pause.
REQ-006 The block SHALL have port i_clear, input, 1 bit: synchronous clear, level-sensitive.
REQ-007 The block SHALL have output o_sec_ones, 4 bits: BCD seconds units, 0-9.
REQ-008 The block SHALL have output o_sec_tens, 4 bits: BCD seconds tens, 0-5.
REQ-009 The block SHALL have output o_min_ones, 4 bits: BCD minutes units, 0-9.
REQ-010 The block SHALL have output o_min_tens, 4 bits: BCD minutes tens, 0 to MINUTE_MOD/10-1.
REQ-011 The block SHALL have output o_running, 1 bit: high while the FSM is in RUN.
REQ-012 The block SHALL have output o_wrap, 1 bit: one-cycle pulse after the full-scale wrap to 00:00.

Function
REQ-013 The FSM SHALL have three states: IDLE (cleared, stopped), RUN and PAUSE.
REQ-014 Start detection SHALL use one register holding the previous i_start_stop; start_edge = i_start_stop & ~prev.
REQ-015 The FSM SHALL make these transitions on start_edge: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-016 i_clear=1 SHALL force IDLE and all digits to 0 on the next edge from any state, and SHALL override start_edge and i_tick in the same cycle.
REQ-017 Counting SHALL occur only when the current state is RUN and i_tick=1; the digits SHALL update on that edge and be visible in the following cycle.
REQ-018 A start_edge and i_tick in the same cycle in IDLE or PAUSE SHALL NOT count the tick; the state SHALL become RUN.
REQ-019 A start_edge and i_tick in the same cycle in RUN SHALL count the tick; the state SHALL become PAUSE.
REQ-020 Carry chain per counted tick: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 (with sec_ones=9) carries to min_ones; min_ones 9->0 carries to min_tens; min_tens MINUTE_MOD/10-1 ->0 completes the full wrap.
REQ-021 A digit SHALL change only on its own carry condition; digits SHALL never hold non-BCD values.
REQ-022 On the full wrap ((MINUTE_MOD-1):59 -> 00:00), o_wrap SHALL be registered high for exactly the next cycle, and the state SHALL stay RUN.
REQ-023 o_wrap SHALL be 0 in all other cycles, including after clear or reset.
REQ-024 o_running SHALL be a registered decode of the state (RUN=1), and SHALL NOT depend combinationally on any input.
REQ-025 i_tick pulses received in IDLE or PAUSE SHALL be discarded and SHALL NOT be queued.

Reset
REQ-026 On i_reset=1, regardless of clock, the block SHALL set state=IDLE, all digits=0, o_running=0, o_wrap=0 and prev start register=0.
REQ-027 A reset asserted mid-count SHALL discard the count immediately.
REQ-028 After reset release, a held-high i_start_stop SHALL produce a start_edge on the first clock edge.

Verification
REQ-029 The bench SHALL cover: reset, start_stop pulse, 75 ticks -> o_running=1, display 01:15, o_wrap never high.
REQ-030 The bench SHALL cover: RUN at 00:59, one tick -> 01:00 (sec_tens 5->0, min_ones 0->1).
REQ-031 The bench SHALL cover: MINUTE_MOD=60, preload by ticking to 59:59, one tick -> 00:00, o_wrap high for exactly 1 cycle, o_running stays 1.
REQ-032 The bench SHALL cover: RUN at 00:10, start edge coincident with tick -> 00:11, PAUSE; 5 further ticks -> still 00:11, o_running=0.
REQ-033 The bench SHALL cover: PAUSE at 00:11, i_clear together with a start edge -> IDLE, 00:00, o_running=0.
REQ-034 The bench SHALL cover: RUN at 00:30, async i_reset pulse between clock edges -> all outputs 0 immediately, before the next edge.
